sram_march_bist: RTL and testbench

- Built-in self-test controller for the sram22 single-port macros (1024x64, 2-lane write mask, 1-cycle read latency).
- Runs a March C- sequence over the full array and compares read data against expected values.
- Reports pass/fail, the first failing address, element and bit mask, and a saturating error count.
- Sits between the SRAM macro and the BIST register interface; the SRAM port mux outside this block gives it ownership while busy=1.

---
 rtl/sram_march_bist.sv | 248 ++++++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March C- built-in self-test controller for a single-port SRAM macro.
// Sequences the six March elements over the full array with one SRAM op per
// cycle. Read data is checked one cycle after each read is issued. The first
// miscompare is recorded, and a saturating count of all miscompares is kept.
//
// state | meaning
// IDLE  | waiting for start, SRAM port quiet
// RUN   | issuing one March op per cycle (10N cycles)
// DRAIN | last read is being compared, no op issued
// DONE  | results held, waiting for a new start
module sram_march_bist #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  pattern,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [2:0]             fail_elem,
    output logic [DATA_WIDTH-1:0]  fail_bits,
    output logic [CNT_WIDTH-1:0]   fail_count,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [2:0]            ELEM_LAST = 3'd5;

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic                    phase_q, phase_d;   // 0: first op at address, 1: write after read
    logic [DATA_WIDTH-1:0]   bg_q, bg_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;
    logic [WMASK_WIDTH-1:0]  wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    rd_q, rd_d;

    logic                    cmp_valid_q;
    logic [DATA_WIDTH-1:0]   cmp_exp_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic [2:0]              cmp_elem_q;

    logic                    fail_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [2:0]              fail_elem_q;
    logic [DATA_WIDTH-1:0]   fail_bits_q;
    logic [CNT_WIDTH-1:0]    fail_count_q;

    logic                    up;
    logic                    at_end;
    logic [2:0]              nxt_elem;
    logic                    nxt_phase;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic                    run_last;

    logic                    accept;
    logic                    iss;
    logic                    iss_wr;
    logic                    iss_wr_bg;
    logic [2:0]              iss_elem;
    logic                    iss_phase;
    logic [ADDR_WIDTH-1:0]   iss_addr;
    logic [DATA_WIDTH-1:0]   iss_bg;

    logic [DATA_WIDTH-1:0]   rd_exp;
    logic [DATA_WIDTH-1:0]   cmp_diff;
    logic                    mism;

    // Successor of the op currently on the SRAM port within the March sequence.
    always_comb begin
        up        = (elem_q == 3'd0) || (elem_q == 3'd1) || (elem_q == 3'd2) || (elem_q == 3'd5);
        at_end    = up ? (addr_q == ADDR_LAST) : (addr_q == '0);
        nxt_elem  = elem_q;
        nxt_phase = 1'b0;
        nxt_addr  = addr_q;
        run_last  = 1'b0;
        if ((elem_q != 3'd0) && (elem_q != ELEM_LAST) && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (!at_end) begin
            nxt_addr = up ? addr_q + 1'b1 : addr_q - 1'b1;
        end else if (elem_q == ELEM_LAST) begin
            run_last = 1'b1;
        end else begin
            nxt_elem = elem_q + 3'd1;
            // E3 and E4 walk downwards, so they start at the top address.
            nxt_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
        end
    end

    // Next-state logic and registered SRAM op for the following cycle.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        phase_d   = phase_q;
        bg_d      = bg_q;
        done_d    = done_q;
        accept    = 1'b0;
        iss       = 1'b0;
        iss_elem  = elem_q;
        iss_phase = phase_q;
        iss_addr  = addr_q;
        iss_bg    = bg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    accept    = 1'b1;
                    done_d    = 1'b0;
                    bg_d      = pattern;
                    iss       = 1'b1;
                    iss_elem  = 3'd0;
                    iss_phase = 1'b0;
                    iss_addr  = '0;
                    iss_bg    = pattern;
                end
            end
            S_RUN: begin
                if (run_last) begin
                    state_d = S_DRAIN;
                end else begin
                    iss       = 1'b1;
                    iss_elem  = nxt_elem;
                    iss_phase = nxt_phase;
                    iss_addr  = nxt_addr;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (iss) begin
            elem_d  = iss_elem;
            phase_d = iss_phase;
        end
        iss_wr    = (iss_elem == 3'd0) || iss_phase;
        iss_wr_bg = (iss_elem == 3'd0) || (iss_elem == 3'd2) || (iss_elem == 3'd4);
        we_d      = iss && iss_wr;
        wmask_d   = (iss && iss_wr) ? '1 : '0;
        addr_d    = iss ? iss_addr : '0;
        din_d     = (iss && iss_wr) ? (iss_wr_bg ? iss_bg : ~iss_bg) : '0;
        rd_d      = iss && !iss_wr;
    end

    // Expected data for the read currently on the port, and the delayed compare.
    always_comb begin
        rd_exp   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg_q : bg_q;
        cmp_diff = sram_dout ^ cmp_exp_q;
        mism     = cmp_valid_q && (cmp_diff != '0);
    end

    // State, sequencer and SRAM port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
            bg_q    <= '0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            bg_q    <= bg_d;
            done_q  <= done_d;
            we_q    <= we_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rd_q    <= rd_d;
        end
    end

    // Compare pipeline: freezes what a read expects, so the write issued in the
    // compare cycle cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
        end else begin
            cmp_valid_q <= rd_q;
            cmp_exp_q   <= rd_exp;
            cmp_addr_q  <= addr_q;
            cmp_elem_q  <= elem_q;
        end
    end

    // Result registers: first-failure capture plus saturating miscompare count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_bits_q  <= '0;
            fail_count_q <= '0;
        end else if (accept) begin
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_bits_q  <= '0;
            fail_count_q <= '0;
        end else if (mism) begin
            if (fail_count_q != '1) begin
                fail_count_q <= fail_count_q + 1'b1;
            end
            if (!fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
                fail_elem_q <= cmp_elem_q;
                fail_bits_q <= cmp_diff;
            end
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;
    assign fail_bits  = fail_bits_q;
    assign fail_count = fail_count_q;
    assign sram_we    = we_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: behavioural 1024x64 SRAM with fault
// injection on the read path, plus a second instance with an 8-bit counter.
module tb_sram_march_bist;

    localparam int N  = 1024;
    localparam int DW = 64;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] pattern;

    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_bits;
    logic [15:0]   fail_count;
    logic          sram_we;
    logic [1:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    logic          busy8, done8, fail8;
    logic [AW-1:0] fail_addr8;
    logic [2:0]    fail_elem8;
    logic [DW-1:0] fail_bits8;
    logic [7:0]    fail_count8;
    logic          sram_we8;
    logic [1:0]    sram_wmask8;
    logic [AW-1:0] sram_addr8;
    logic [DW-1:0] sram_din8;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] dout_raw;
    logic [AW-1:0] rd_addr_q;
    int            fault_mode;   // 0 none, 1 bit0 stuck-at-1 on addr 5, 2 invert all reads

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_march_bist dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .fail_bits(fail_bits), .fail_count(fail_count),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram_march_bist #(.CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .busy(busy8), .done(done8), .fail(fail8), .fail_addr(fail_addr8),
        .fail_elem(fail_elem8), .fail_bits(fail_bits8), .fail_count(fail_count8),
        .sram_we(sram_we8), .sram_wmask(sram_wmask8), .sram_addr(sram_addr8),
        .sram_din(sram_din8), .sram_dout(sram_dout)
    );

    // SRAM model driven by the 16-bit instance; both instances run in lockstep.
    always @(posedge clk) begin
        if (sram_we) begin
            if (sram_wmask[0]) mem[sram_addr][31:0]  <= sram_din[31:0];
            if (sram_wmask[1]) mem[sram_addr][63:32] <= sram_din[63:32];
        end else begin
            dout_raw  <= mem[sram_addr];
            rd_addr_q <= sram_addr;
        end
    end

    assign sram_dout = (fault_mode == 2) ? ~dout_raw :
                       ((fault_mode == 1) && (rd_addr_q == 10'd5)) ? (dout_raw | 64'h1) :
                       dout_raw;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] opv(input logic we, input logic [1:0] wm,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {51'd0, we, wm, a, d};
    endfunction

    // Starts a run, walks it to completion (or abort), checking selected ops.
    task automatic run_full(input logic [DW-1:0] pat, input bit chk_ops, input int pulse_at,
                            input int abort_at, output int t_done, output int n_wr);
        logic [127:0] obs;
        @(negedge clk);
        pattern = pat;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        t_done  = -1;
        n_wr    = 0;
        for (int c = 0; c <= 10 * N + 20; c++) begin
            obs = opv(sram_we, sram_wmask, sram_addr, sram_din);
            if (c == 0) begin
                chk("start_busy", busy, 1'b1);
                chk("start_done_clr", done, 1'b0);
                chk("start_fail_clr", {fail, fail_count}, 17'd0);
            end
            if (chk_ops) begin
                if (c < 3)         chk("e0_write",    obs, opv(1'b1, 2'b11, c[AW-1:0], pat));
                if (c == N - 1)    chk("e0_last",     obs, opv(1'b1, 2'b11, 10'd1023, pat));
                if (c == N)        chk("e1_read0",    obs, opv(1'b0, 2'b00, 10'd0, '0));
                if (c == N + 1)    chk("e1_write0",   obs, opv(1'b1, 2'b11, 10'd0, ~pat));
                if (c == N + 2)    chk("e1_read1",    obs, opv(1'b0, 2'b00, 10'd1, '0));
                if (c == 3 * N + 1) chk("e2_write0",  obs, opv(1'b1, 2'b11, 10'd0, pat));
                if (c == 5 * N)    chk("e3_read_top", obs, opv(1'b0, 2'b00, 10'd1023, '0));
                if (c == 5 * N + 2) chk("e3_read_dn", obs, opv(1'b0, 2'b00, 10'd1022, '0));
                if (c == 7 * N + 1) chk("e4_write",   obs, opv(1'b1, 2'b11, 10'd1023, pat));
                if (c == 10 * N - 1) chk("e5_last",   obs, opv(1'b0, 2'b00, 10'd1023, '0));
                if (c == 10 * N)   chk("drain", {busy, done, obs}, {2'b10, opv(1'b0, 2'b00, 10'd0, '0)});
            end
            if (sram_we) n_wr++;
            if (c == pulse_at)     start = 1'b1;
            if (c == pulse_at + 1) start = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_outputs",
                    {busy, done, fail, fail_count, fail_addr, fail_elem, sram_we, sram_wmask, sram_addr},
                    '0);
                chk("abort_data", {fail_bits, sram_din}, '0);
                t_done = c;
                break;
            end
            if (done) begin
                t_done = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    int t_done, n_wr, q_wr;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        fault_mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, fail, fail_count, fail_addr, fail_elem}, '0);
        chk("reset_port", {sram_we, sram_wmask, sram_addr, sram_din}, '0);
        rst = 1'b0;

        // Clean run, background 0.
        run_full(64'h0, 1'b1, -1, -1, t_done, n_wr);
        chk("clean_latency", t_done, 10 * N + 1);
        chk("clean_writes", n_wr, 5 * N);
        chk("clean_result", {busy, fail, fail_count}, 17'd0);

        // Stuck bit on addr 5; start issued from DONE. Misses only in r0 elements E1, E3, E5.
        fault_mode = 1;
        run_full(64'h0, 1'b0, -1, -1, t_done, n_wr);
        chk("stuck_latency", t_done, 10 * N + 1);
        chk("stuck_first", {fail, fail_addr, fail_elem}, {1'b1, 10'd5, 3'd1});
        chk("stuck_bits", fail_bits, 64'h1);
        chk("stuck_count", fail_count, 16'd3);
        chk("stuck_count8", fail_count8, 8'd3);
        @(negedge clk);
        chk("done_hold", {done, fail, fail_count}, {2'b11, 16'd3});
        fault_mode = 0;

        // Mixed background with an ignored start pulse mid-run.
        run_full(64'hA5A5_5A5A_F00F_0FF0, 1'b1, 100, -1, t_done, n_wr);
        chk("pat_latency", t_done, 10 * N + 1);
        chk("pat_result", {fail, fail_count}, 17'd0);

        // Asynchronous abort at cycle 3000, then no writes.
        run_full(64'h0, 1'b0, -1, 3000, t_done, n_wr);
        chk("abort_reached", t_done, 3000);
        q_wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (sram_we) q_wr++;
        end
        chk("abort_no_writes", {q_wr[7:0], busy, done}, 10'd0);

        // Clean run after abort.
        run_full(64'hFFFF_0000_1234_8765, 1'b1, -1, -1, t_done, n_wr);
        chk("post_abort_latency", t_done, 10 * N + 1);
        chk("post_abort_result", {fail, fail_count}, 17'd0);

        // Every read inverted: all 5N reads (E1..E5) miss; 8-bit counter saturates.
        fault_mode = 2;
        run_full(64'h0, 1'b0, -1, -1, t_done, n_wr);
        chk("inv_latency", t_done, 10 * N + 1);
        chk("inv_first", {fail, fail_addr, fail_elem}, {1'b1, 10'd0, 3'd1});
        chk("inv_bits", fail_bits, {64{1'b1}});
        chk("inv_count", fail_count, 16'd5120);
        chk("inv_count8", {fail8, fail_count8}, {1'b1, 8'd255});
        fault_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
